// File: rtl/ctrl_rw_arbiter_if.sv
// Request/command bundle between the host request path, the read/write
// arbiter and the ACT/CAS sequencers. The arbiter takes the slave view.
interface ctrl_rw_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
);
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_auto;
  logic              rd_req_ready;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic              wr_req_auto;
  logic              wr_req_ready;
  logic              cmd_valid;
  logic [2:0]        cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic              turnaround;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_auto,
    input  rd_req_ready,
    output wr_req_valid, wr_req_addr, wr_req_auto,
    input  wr_req_ready,
    input  cmd_valid, cmd_rw, cmd_addr, turnaround, rd_cnt, wr_cnt,
    output cmd_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_auto,
    output rd_req_ready,
    input  wr_req_valid, wr_req_addr, wr_req_auto,
    output wr_req_ready,
    output cmd_valid, cmd_rw, cmd_addr, turnaround, rd_cnt, wr_cnt,
    input  cmd_ready
  );
endinterface

// File: rtl/ctrl_rw_arbiter.sv
// Read/write request arbiter: two request FIFOs feeding one command slot.
// Same-direction requests are batched to limit bus turnarounds, and a
// write drain is forced once the write queue crosses its high watermark.
module ctrl_rw_arbiter #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 32,
  parameter int WR_HI     = 6,
  parameter int WR_LO     = 2,
  parameter int MAX_BATCH = 4
) (
  input  logic                CK_t,
  input  logic                reset_n,
  ctrl_rw_arbiter_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 1;
  localparam int BW = $clog2(MAX_BATCH + 1);

  // Command encodings shared with the ACT/CAS sequencers.
  localparam logic [2:0] RD_R  = 3'd0;
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] HI_CNT    = CW'(WR_HI);
  localparam logic [CW-1:0] LO_CNT    = CW'(WR_LO);
  localparam logic [BW-1:0] BATCH_MAX = BW'(MAX_BATCH);

  typedef enum logic [1:0] {ARB_IDLE, ARB_READ, ARB_WRITE, ARB_DRAIN} arb_mode_e;

  // Index 0 is the read queue, index 1 the write queue.
  logic [1:0]             req_valid, req_auto, req_ready, pop;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][EW-1:0]     head;
  logic [1:0][CW-1:0]     cnt;

  assign req_valid = {bus.wr_req_valid, bus.rd_req_valid};
  assign req_auto  = {bus.wr_req_auto, bus.rd_req_auto};
  assign req_addr  = {bus.wr_req_addr, bus.rd_req_addr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] mem [DEPTH];
      logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          push;

      // Readiness ignores a same-cycle pop, so a full queue never accepts.
      assign req_ready[gi] = reset_n && (cnt_q != FULL_CNT);
      assign push          = req_valid[gi] && req_ready[gi];
      assign head[gi]      = mem[rp_q];
      assign cnt[gi]       = cnt_q;

      // Entry storage; validity is tracked by the pointers, so no reset.
      always_ff @(posedge CK_t) begin
        if (push) mem[wp_q] <= {req_addr[gi], req_auto[gi]};
      end

      // Pointer and occupancy update; pointers wrap naturally at DEPTH.
      always_comb begin
        wp_d  = wp_q + PW'(push);
        rp_d  = rp_q + PW'(pop[gi]);
        cnt_d = cnt_q + CW'(push) - CW'(pop[gi]);
      end

      // Pointer and occupancy registers.
      always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
          wp_q  <= '0;
          rp_q  <= '0;
          cnt_q <= '0;
        end else begin
          wp_q  <= wp_d;
          rp_q  <= rp_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  arb_mode_e         mode_q, mode_d;
  logic [BW-1:0]     batch_q, batch_d;
  logic              last_dir_q, last_dir_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [2:0]        cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              turnaround_q, turnaround_d;
  logic              slot_free, issue, dir, head_auto;
  logic              rd_any, wr_any, wr_hi, wr_lo, batch_full;

  assign slot_free  = !cmd_valid_q || bus.cmd_ready;
  assign rd_any     = (cnt[0] != '0);
  assign wr_any     = (cnt[1] != '0);
  assign wr_hi      = (cnt[1] >= HI_CNT);
  assign wr_lo      = (cnt[1] <= LO_CNT);
  assign batch_full = (batch_q == BATCH_MAX);

  // Mode transitions and direction selection from the pre-edge counts.
  always_comb begin
    mode_d = mode_q;
    issue  = 1'b0;
    dir    = 1'b0;
    if (slot_free) begin
      unique case (mode_q)
        ARB_IDLE: begin
          if (wr_hi)       begin mode_d = ARB_DRAIN; issue = 1'b1; dir = 1'b1; end
          else if (rd_any) begin mode_d = ARB_READ;  issue = 1'b1; dir = 1'b0; end
          else if (wr_any) begin mode_d = ARB_WRITE; issue = 1'b1; dir = 1'b1; end
        end
        ARB_READ: begin
          if (wr_hi) begin mode_d = ARB_DRAIN; issue = 1'b1; dir = 1'b1; end
          else if (!rd_any) begin
            if (wr_any) begin mode_d = ARB_WRITE; issue = 1'b1; dir = 1'b1; end
            else              mode_d = ARB_IDLE;
          end
          else if (batch_full && wr_any) begin mode_d = ARB_WRITE; issue = 1'b1; dir = 1'b1; end
          else begin issue = 1'b1; dir = 1'b0; end
        end
        ARB_WRITE: begin
          if (wr_hi) begin mode_d = ARB_DRAIN; issue = 1'b1; dir = 1'b1; end
          else if (!wr_any) begin
            if (rd_any) begin mode_d = ARB_READ; issue = 1'b1; dir = 1'b0; end
            else              mode_d = ARB_IDLE;
          end
          else if (batch_full && rd_any) begin mode_d = ARB_READ; issue = 1'b1; dir = 1'b0; end
          else begin issue = 1'b1; dir = 1'b1; end
        end
        ARB_DRAIN: begin
          if (wr_lo) begin
            if (rd_any)      begin mode_d = ARB_READ;  issue = 1'b1; dir = 1'b0; end
            else if (wr_any) begin mode_d = ARB_WRITE; issue = 1'b1; dir = 1'b1; end
            else                   mode_d = ARB_IDLE;
          end else begin
            issue = 1'b1;
            dir   = 1'b1;
          end
        end
        default: mode_d = ARB_IDLE;
      endcase
    end
  end

  // Command slot load, FIFO pop, batch counting and turnaround detection.
  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_rw_d     = cmd_rw_q;
    cmd_addr_d   = cmd_addr_q;
    batch_d      = batch_q;
    last_dir_d   = last_dir_q;
    turnaround_d = 1'b0;
    pop          = 2'b00;
    head_auto    = head[dir][0];
    if (slot_free) begin
      cmd_valid_d = issue;
      if (issue) begin
        pop[dir]     = 1'b1;
        cmd_addr_d   = head[dir][EW-1:1];
        cmd_rw_d     = dir ? (head_auto ? WRA_R : WR_R) : (head_auto ? RDA_R : RD_R);
        turnaround_d = (dir != last_dir_q);
        if (dir != last_dir_q) batch_d = BW'(1);
        else if (!batch_full)  batch_d = batch_q + BW'(1);
        last_dir_d   = dir;
      end
    end
  end

  // Arbiter state and command slot registers.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= ARB_IDLE;
      batch_q      <= '0;
      last_dir_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_rw_q     <= RD_R;
      cmd_addr_q   <= '0;
      turnaround_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      batch_q      <= batch_d;
      last_dir_q   <= last_dir_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_rw_q     <= cmd_rw_d;
      cmd_addr_q   <= cmd_addr_d;
      turnaround_q <= turnaround_d;
    end
  end

  assign bus.rd_req_ready = req_ready[0];
  assign bus.wr_req_ready = req_ready[1];
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_rw       = cmd_rw_q;
  assign bus.cmd_addr     = cmd_addr_q;
  assign bus.turnaround   = turnaround_q;
  assign bus.rd_cnt       = cnt[0];
  assign bus.wr_cnt       = cnt[1];
endmodule

// File: tb/tb_ctrl_rw_arbiter.sv
// Randomized and directed bench for ctrl_rw_arbiter, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_ctrl_rw_arbiter;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 32;
  localparam int WR_HI     = 6;
  localparam int WR_LO     = 2;
  localparam int MAX_BATCH = 4;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  localparam logic [2:0] RD_R  = 3'd0;
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  logic CK_t    = 1'b0;
  logic reset_n = 1'b0;

  ctrl_rw_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  ctrl_rw_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WR_HI(WR_HI), .WR_LO(WR_LO), .MAX_BATCH(MAX_BATCH)
  ) dut (
    .CK_t   (CK_t),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 CK_t = ~CK_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ap;
  } req_t;

  req_t              rq[$];
  req_t              wq[$];
  bit                m_valid;
  logic [2:0]        m_rw;
  logic [ADDR_W-1:0] m_addr;
  bit                m_turn;
  int                m_phase;   // 0 idle, 1 reading, 2 writing, 3 draining
  int                m_run;     // consecutive grants in the current direction
  int                m_last;    // 0 read, 1 write

  task automatic model_reset();
    rq.delete();
    wq.delete();
    m_valid = 0; m_rw = RD_R; m_addr = '0; m_turn = 0;
    m_phase = 0; m_run = 0; m_last = 0;
  endtask

  // Choose a direction (-1 = nothing) from queue lengths and phase.
  task automatic choose(input int nr, input int nw, output int d);
    int n[2];
    int cur, oth;
    n[0] = nr; n[1] = nw;
    d = -1;
    if (m_phase == 0) begin
      if (nw >= WR_HI)  begin m_phase = 3; d = 1; end
      else if (nr > 0)  begin m_phase = 1; d = 0; end
      else if (nw > 0)  begin m_phase = 2; d = 1; end
    end else if (m_phase == 3) begin
      if (nw > WR_LO) d = 1;
      else if (nr > 0) begin m_phase = 1; d = 0; end
      else if (nw > 0) begin m_phase = 2; d = 1; end
      else m_phase = 0;
    end else begin
      cur = m_phase - 1;
      oth = 1 - cur;
      if (nw >= WR_HI) begin m_phase = 3; d = 1; end
      else if (n[cur] == 0) begin
        if (n[oth] > 0) begin m_phase = oth + 1; d = oth; end
        else m_phase = 0;
      end else if (m_run >= MAX_BATCH && n[oth] > 0) begin
        m_phase = oth + 1; d = oth;
      end else d = cur;
    end
  endtask

  task automatic model_step();
    int   nr, nw, d;
    bit   rd_acc, wr_acc;
    req_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    nr = rq.size();
    nw = wq.size();
    rd_acc = bus.rd_req_valid && (nr < DEPTH);
    wr_acc = bus.wr_req_valid && (nw < DEPTH);
    if (!m_valid || bus.cmd_ready) begin
      choose(nr, nw, d);
      if (d < 0) begin
        m_valid = 0;
        m_turn  = 0;
      end else begin
        if (d == 0) e = rq.pop_front();
        else        e = wq.pop_front();
        m_valid = 1;
        m_addr  = e.addr;
        m_rw    = (d == 0) ? (e.ap ? RDA_R : RD_R) : (e.ap ? WRA_R : WR_R);
        m_turn  = (d != m_last);
        m_run   = (d != m_last) ? 1 : ((m_run < MAX_BATCH) ? m_run + 1 : MAX_BATCH);
        m_last  = d;
      end
    end else begin
      m_turn = 0;
    end
    if (rd_acc) begin e.addr = bus.rd_req_addr; e.ap = bus.rd_req_auto; rq.push_back(e); end
    if (wr_acc) begin e.addr = bus.wr_req_addr; e.ap = bus.wr_req_auto; wq.push_back(e); end
  endtask

  task automatic compare();
    chk("rd_cnt", bus.rd_cnt, rq.size());
    chk("wr_cnt", bus.wr_cnt, wq.size());
    chk("rd_req_ready", bus.rd_req_ready, reset_n && (rq.size() < DEPTH));
    chk("wr_req_ready", bus.wr_req_ready, reset_n && (wq.size() < DEPTH));
    chk("cmd_valid", bus.cmd_valid, m_valid);
    if (m_valid) begin
      chk("cmd_rw", bus.cmd_rw, m_rw);
      chk("cmd_addr", bus.cmd_addr, m_addr);
    end
    chk("turnaround", bus.turnaround, m_turn);
  endtask

  // ---------------- stimulus helpers ----------------
  logic [31:0] seq_dir, seq_ta;
  int          n_acc;

  // Log the command about to be accepted, then advance one cycle.
  task automatic tick();
    if (reset_n && bus.cmd_valid && bus.cmd_ready) begin
      if (n_acc < 32) begin
        seq_dir[n_acc] = (bus.cmd_rw == WR_R) || (bus.cmd_rw == WRA_R);
        seq_ta[n_acc]  = bus.turnaround;
      end
      $display("cmd %0d: rw=%0d addr=0x%08h turnaround=%0b", n_acc, bus.cmd_rw, bus.cmd_addr, bus.turnaround);
      n_acc++;
    end
    @(posedge CK_t);
    model_step();
    @(negedge CK_t);
    compare();
  endtask

  task automatic idle_inputs();
    bus.rd_req_valid = 0; bus.rd_req_addr = '0; bus.rd_req_auto = 0;
    bus.wr_req_valid = 0; bus.wr_req_addr = '0; bus.wr_req_auto = 0;
    bus.cmd_ready    = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    #1;
    model_reset();
    compare();
    chk("rst_cmd_rw", bus.cmd_rw, RD_R);
    chk("rst_cmd_addr", bus.cmd_addr, 0);
    repeat (2) tick();
    reset_n = 1;
    #1;
    compare();
    n_acc = 0; seq_dir = '0; seq_ta = '0;
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a, input logic ap);
    bus.rd_req_valid = 1; bus.rd_req_addr = a; bus.rd_req_auto = ap;
    tick();
    bus.rd_req_valid = 0;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic ap);
    bus.wr_req_valid = 1; bus.wr_req_addr = a; bus.wr_req_auto = ap;
    tick();
    bus.wr_req_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    @(negedge CK_t);

    // Single read latency.
    do_reset();
    bus.cmd_ready = 1;
    push_rd(32'h10, 1'b1);
    chk("t1_not_yet", bus.cmd_valid, 0);
    tick();
    chk("t1_valid", bus.cmd_valid, 1);
    chk("t1_rw", bus.cmd_rw, RDA_R);
    chk("t1_addr", bus.cmd_addr, 32'h10);
    chk("t1_turn", bus.turnaround, 0);
    tick();
    chk("t1_done", bus.cmd_valid, 0);

    // Batching: 6 reads, 2 writes.
    do_reset();
    for (int i = 0; i < 6; i++) push_rd(32'h100 + i, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2; i++) push_wr(32'h200 + i, 1'($urandom_range(0, 1)));
    bus.cmd_ready = 1;
    repeat (12) tick();
    chk("t2_count", n_acc, 8);
    chk("t2_order", seq_dir[7:0], 8'b0011_0000);
    chk("t2_turn", seq_ta[7:0], 8'b0101_0000);

    // Write drain above the watermark.
    do_reset();
    for (int i = 0; i < 3; i++) push_rd(32'h400 + i, 1'b0);
    for (int i = 0; i < 6; i++) push_wr(32'h500 + i, 1'b1);
    bus.cmd_ready = 1;
    repeat (14) tick();
    chk("t3_count", n_acc, 9);
    chk("t3_order", seq_dir[8:0], 9'b1_1001_1110);
    chk("t3_turn", seq_ta[8:0], 9'b0_1010_0010);

    // Stall hold and write FIFO full.
    do_reset();
    push_rd(32'h44, 1'b0);
    for (int i = 0; i < 9; i++) begin
      push_wr(32'h300 + i, 1'b0);
      chk("t4_hold_valid", bus.cmd_valid, 1);
      chk("t4_hold_rw", bus.cmd_rw, RD_R);
      chk("t4_hold_addr", bus.cmd_addr, 32'h44);
    end
    chk("t4_wr_full", bus.wr_cnt, DEPTH);
    chk("t4_wr_ready", bus.wr_req_ready, 0);
    bus.cmd_ready = 1;
    repeat (14) tick();
    chk("t4_count", n_acc, 9);
    chk("t4_order", seq_dir[8:0], 9'b1_1111_1110);
    chk("t4_turn", seq_ta[8:0], 9'b0_0000_0010);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 4; i++) push_rd(32'h600 + i, 1'b1);
    for (int i = 0; i < 2; i++) push_wr(32'h700 + i, 1'b0);
    chk("t5_rd_q", bus.rd_cnt, 3);
    chk("t5_wr_q", bus.wr_cnt, 2);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("t5_valid", bus.cmd_valid, 0);
    chk("t5_rd_cnt", bus.rd_cnt, 0);
    chk("t5_wr_cnt", bus.wr_cnt, 0);
    chk("t5_rd_ready", bus.rd_req_ready, 0);
    chk("t5_wr_ready", bus.wr_req_ready, 0);
    repeat (2) tick();
    reset_n = 1;
    bus.cmd_ready = 1;
    repeat (6) begin
      tick();
      chk("t5_no_stale", bus.cmd_valid, 0);
    end

    // Random traffic through pointer wrap-around.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.rd_req_valid = 1'($urandom_range(0, 1));
      bus.rd_req_addr  = $urandom;
      bus.rd_req_auto  = 1'($urandom_range(0, 1));
      bus.wr_req_valid = 1'($urandom_range(0, 1));
      bus.wr_req_addr  = $urandom;
      bus.wr_req_auto  = 1'($urandom_range(0, 1));
      bus.cmd_ready    = ($urandom_range(0, 99) < ((i < 200) ? 40 : 85));
      tick();
      chk("t6_rd_bound", bus.rd_cnt <= DEPTH, 1);
      chk("t6_wr_bound", bus.wr_cnt <= DEPTH, 1);
    end
    idle_inputs();
    bus.cmd_ready = 1;
    repeat (20) tick();
    chk("t6_drained_rd", bus.rd_cnt, 0);
    chk("t6_drained_wr", bus.wr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
